// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One full-adder cell; the caller supplies the inverted subtrahend bit.
module sub_bit_cell (
    input  logic a,
    input  logic b_inv,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b_inv ^ cin;
    assign cout = (a & b_inv) | (cin & (a ^ b_inv));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single carry flop.
// Optional SERIAL_SUB_SAT_EN saturates the difference on signed overflow.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int CW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             live_q, live_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             sum;
    logic             cout;
    logic             last;
    logic             ovf_fin;
    logic [WIDTH-1:0] res_fin;
    logic [WIDTH-1:0] diff_fin;

    sub_bit_cell u_cell (
        .a     (a_q[0]),
        .b_inv (b_q[0]),
        .cin   (carry_q),
        .s     (sum),
        .cout  (cout)
    );

    assign in_ready     = live_q && (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_diff     = diff_q;
    assign out_borrow   = borrow_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

    // On the last bit carry_q is the carry into the MSB.
    always_comb begin
        last     = (cnt_q == CW'(WIDTH - 1));
        res_fin  = {sum, res_q[WIDTH-1:1]};
        ovf_fin  = carry_q ^ cout;
        diff_fin = res_fin;
`ifdef SERIAL_SUB_SAT_EN
        // Overflow flips the sign, so a wrapped MSB of 1 means a was non-negative.
        if (ovf_fin) begin
            diff_fin = res_fin[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        live_d   = 1'b1;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = ~in_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d   = res_fin;
                carry_d = cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    diff_d   = diff_fin;
                    borrow_d = ~cout;
                    ovf_d    = ovf_fin;
                    zero_d   = (diff_fin == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            live_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            live_q   <= live_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor with an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_borrow;
    logic         out_overflow;
    logic         out_zero;

    always #5 clock = ~clock;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_diff     (out_diff),
        .out_borrow   (out_borrow),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           c;
    } req_t;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        logic         z;
    } res_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    req_t   exp_q[$];
    int     acc_log[$];
    logic   ov_prev = 1'b0;
    int     vstart = 0;
    req_t   sb_req;
    res_t   sb_res;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Integer arithmetic straight from the definition of a - b.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   r;
        longint sa, sb, sd, lim;
        lim  = longint'(1) << (W - 1);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sd   = sa - sb;
        r.ov = (sd >= lim) || (sd < -lim);
        r.br = (a < b);
        r.d  = W'(longint'(a) - longint'(b));
`ifdef SERIAL_SUB_SAT_EN
        if (r.ov) r.d = (sa >= 0) ? W'(lim - 1) : W'(lim);
`endif
        r.z  = (r.d == '0);
        return r;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: handshakes seen at negedge complete on the next posedge.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) vstart = cyc;
            ov_prev = out_valid;
            if (in_valid && in_ready) begin
                sb_req.a = in_a;
                sb_req.b = in_b;
                sb_req.c = cyc;
                exp_q.push_back(sb_req);
                acc_log.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stray_out", out_valid, 1'b0);
                end else begin
                    sb_req = exp_q.pop_front();
                    sb_res = model(sb_req.a, sb_req.b);
                    check("sb_diff", out_diff, sb_res.d);
                    check("sb_borrow", out_borrow, sb_res.br);
                    check("sb_ovf", out_overflow, sb_res.ov);
                    check("sb_zero", out_zero, sb_res.z);
                    check("sb_latency", vstart - sb_req.c - 1, W);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("accept_timeout", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic directed(input string pfx, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] d,
                            input logic br, input logic ov, input logic z);
        out_ready = 1'b1;
        send(a, b);
        wait_valid();
        check({pfx, "_diff"}, out_diff, d);
        check({pfx, "_borrow"}, out_borrow, br);
        check({pfx, "_ovf"}, out_overflow, ov);
        check({pfx, "_zero"}, out_zero, z);
        step();
        check({pfx, "_done"}, out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [W-1:0] sat80;
        logic [W-1:0] corner [4];
        corner[0] = 8'h00;
        corner[1] = 8'h7F;
        corner[2] = 8'h80;
        corner[3] = 8'hFF;
`ifdef SERIAL_SUB_SAT_EN
        sat80 = 8'h80;
`else
        sat80 = 8'h7F;
`endif
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        step();
        check("rst_ready", in_ready, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_diff", out_diff, 0);
        check("rst_flags", {out_borrow, out_overflow, out_zero}, 0);
        #3 resetn = 1'b1;
        check("rel_ready_pre", in_ready, 1'b0);
        step();
        check("rel_ready", in_ready, 1'b1);

        directed("t_100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b0);
        directed("t_10_20", 8'd10, 8'd20, 8'hF6, 1'b1, 1'b0, 1'b0);

        // Reset during the fourth BUSY cycle discards the operation.
        send(8'hAA, 8'h0F);
        repeat (3) step();
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_diff", out_diff, 0);
        check("mid_rst_borrow", out_borrow, 1'b0);
        step();
        step();
        #3 resetn = 1'b1;
        check("mid_rel_ready_pre", in_ready, 1'b0);
        step();
        check("mid_rel_ready", in_ready, 1'b1);
        seen = 0;
        repeat (12) begin
            step();
            if (out_valid) seen++;
        end
        check("no_stale_valid", seen, 0);
        directed("t_33_11", 8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);

        directed("t_80_01", 8'h80, 8'h01, sat80, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        send(8'd5, 8'd5);
        wait_valid();
        repeat (5) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            step();
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_diff", out_diff, 0);
            check("hold_zero", out_zero, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("hold_release", out_valid, 1'b0);
        check("hold_keep_diff", out_zero, 1'b1);
        check("hold_idle_ready", in_ready, 1'b1);

        // Back-to-back with in_valid held high.
        acc_log.delete();
        in_valid = 1'b1;
        repeat (35) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();
        check("b2b_count", acc_log.size() >= 3, 1'b1);
        for (int i = 1; i < acc_log.size(); i++)
            check("b2b_gap", acc_log[i] - acc_log[i-1], W + 2);

        // Random traffic with random backpressure and corner operands.
        repeat (600) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                                    : W'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                                    : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) step();
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
